// File: rtl/octal_rr_arbiter.sv
// Eight-way round-robin arbiter with registered one-hot grant, binary index and hold timeout.
// Optional owner lock is compiled in with ARB_LOCK_EN: it masks the timeout and freezes the hold counter.
module octal_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic              LP_TO_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] LP_LAST  = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  logic [1:0]        r_state;
  logic [2:0]        r_ptr;
  logic [HOLD_W-1:0] r_hold;
  logic [7:0]        r_gnt;
  logic [2:0]        r_gnt_idx;
  logic              r_timeout;

  logic [2:0] w_sel;
  logic       w_found;
  logic       w_lock;
  logic       w_rel_done;
  logic       w_rel_req;
  logic       w_rel_tmo;
  logic       w_release;

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  // Rotating priority search: first requester at or after r_ptr, wrapping mod 8.
  always_comb begin
    logic [2:0] cand;
    w_sel   = 3'd0;
    w_found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = r_ptr + 3'(k);
      if (!w_found && req[cand]) begin
        w_sel   = cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_rel_done = done;
  assign w_rel_req  = ~req[r_gnt_idx];
  assign w_rel_tmo  = LP_TO_EN && !w_lock && (r_hold == LP_LAST);
  assign w_release  = w_rel_done | w_rel_req | w_rel_tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 3'd0;
      r_hold    <= '0;
      r_gnt     <= 8'd0;
      r_gnt_idx <= 3'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt     <= 8'd1 << w_sel;
            r_gnt_idx <= w_sel;
            r_hold    <= '0;
            r_state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_gnt     <= 8'd0;
            r_gnt_idx <= 3'd0;
            r_ptr     <= r_gnt_idx + 3'd1;
            r_state   <= ST_GAP;
            // A timeout is only reported when the owner neither finished nor withdrew.
            r_timeout <= w_rel_tmo & ~w_rel_done & ~w_rel_req;
          end else if (!w_lock) begin
            r_hold <= sat_inc(r_hold);
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = |r_gnt;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_octal_rr_arbiter.sv
// Scoreboard bench for octal_rr_arbiter: stimulus queues expected grants, a negedge monitor checks them.
module tb_octal_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic       lock;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [2:0] idx;
    int         len;   // 0 = length not checked
    bit         to;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   cur_ok = 1'b0;
  bit   prev_valid = 1'b0;
  int   run_len = 0;

  always #5 clk = ~clk;

  octal_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
`ifdef ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic lvl, input string name);
    int n;
    n = 0;
    while (gnt_valid !== lvl && n < 60) begin
      step();
      n++;
    end
    if (gnt_valid !== lvl) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: gnt_valid stuck at %b, expected %b", name, gnt_valid, lvl);
    end
  endtask

  task automatic push(input logic [2:0] idx, input int len, input bit to);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.to  = to;
    exp_q.push_back(e);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  // Monitor: grant starts pop the scoreboard; grant ends check length and timeout.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      chk("idx_enc", {29'd0, gnt_idx}, {29'd0, enc(gnt)});
      chk("valid_or", {31'd0, gnt_valid}, {31'd0, |gnt});
      if (gnt_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          cur_ok = 1'b0;
          $display("FAIL unexpected_grant: got idx %0d, expected none", gnt_idx);
        end else begin
          cur = exp_q.pop_front();
          cur_ok = 1'b1;
          chk("grant_idx", {29'd0, gnt_idx}, {29'd0, cur.idx});
        end
        run_len = 1;
      end else if (gnt_valid) begin
        run_len++;
      end else if (prev_valid) begin
        if (cur_ok) begin
          if (cur.len != 0) chk("grant_len", run_len, cur.len);
          chk("timeout_at_release", {31'd0, timeout}, {31'd0, cur.to});
        end
        cur_ok = 1'b0;
      end else begin
        chk("timeout_idle", {31'd0, timeout}, 32'd0);
      end
      prev_valid = gnt_valid;
    end
  end

  initial begin
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;
    lock = 1'b0;

    // Reset held two cycles with all requests asserted.
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_gnt", {24'd0, gnt}, 32'd0);
      chk("rst_idx", {29'd0, gnt_idx}, 32'd0);
      chk("rst_valid", {31'd0, gnt_valid}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
    end
    rst = 1'b0;
    req = 8'h00;
    mon_en = 1'b1;
    step();

    // done while idle does nothing
    pulse_done();
    step();
    chk("done_idle_valid", {31'd0, gnt_valid}, 32'd0);

    // Single requester 5: done release, then re-grant that times out.
    push(3'd5, 1, 1'b0);
    push(3'd5, 4, 1'b1);
    req = 8'b0010_0000;
    wait_valid(1'b1, "single_grant");
    chk("single_gnt", {24'd0, gnt}, 32'h20);
    pulse_done();
    chk("single_released", {31'd0, gnt_valid}, 32'd0);
    wait_valid(1'b1, "single_regrant");
    wait_valid(1'b0, "single_timeout");
    req = 8'h00;

    // Timeout on requester 2, then the next owner is searched from ptr=3.
    push(3'd2, 4, 1'b1);
    req = 8'b0000_0100;
    wait_valid(1'b1, "to_grant");
    wait_valid(1'b0, "to_release");
    chk("to_pulse", {31'd0, timeout}, 32'd1);
    push(3'd3, 1, 1'b0);
    req = 8'hFF;
    wait_valid(1'b1, "ptr3_grant");
    pulse_done();

    // Reset mid-grant (owner 4) drops the grant and returns ptr to 0.
    push(3'd4, 0, 1'b0);
    wait_valid(1'b1, "mid_grant");
    rst = 1'b1;
    step();
    chk("midrst_gnt", {24'd0, gnt}, 32'd0);
    chk("midrst_valid", {31'd0, gnt_valid}, 32'd0);
    rst = 1'b0;

    // Rotation with all requesting: 0..7 then wrap to 0.
    for (int i = 0; i < 9; i++) push(3'(i % 8), 1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      wait_valid(1'b1, "rot_grant");
      pulse_done();
    end
    req = 8'h00;

    // done coincides with the timeout cycle: single release, no timeout pulse.
    wait_valid(1'b0, "pre_sim");
    step();
    step();
    push(3'd3, 4, 1'b0);
    req = 8'b0000_1001;
    wait_valid(1'b1, "sim_grant");
    req = 8'b1111_1001;
    step();
    step();
    step();
    pulse_done();
    req = 8'h00;

    // Owner withdraws its request: release on req drop, from ptr=4 owner is 3.
    step();
    step();
    push(3'd3, 2, 1'b0);
    req = 8'b0000_1000;
    wait_valid(1'b1, "drop_grant");
    step();
    req = 8'h00;
    step();
    chk("drop_released", {31'd0, gnt_valid}, 32'd0);
    step();
    step();

`ifdef ARB_LOCK_EN
    // Lock holds owner 1 well past MAX_HOLD; dropping req releases and advances ptr.
    push(3'd1, 13, 1'b0);
    lock = 1'b1;
    req  = 8'b0000_0010;
    wait_valid(1'b1, "lock_grant");
    for (int i = 0; i < 12; i++) begin
      step();
      chk("lock_held", {31'd0, gnt_valid}, 32'd1);
    end
    req = 8'h00;
    step();
    lock = 1'b0;
    push(3'd2, 1, 1'b0);
    req = 8'hFF;
    wait_valid(1'b1, "lock_next");
    pulse_done();
    req = 8'h00;
    step();
    step();
    step();
`endif

    step();
    step();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
